// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over an 8N1 UART line and writes it into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte; the default build has no checksum.
module imem_loader #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count,
    output logic [2:0]  dbg_state,
    output logic [1:0]  dbg_rx_state
);
    localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [16:0]      DEPTH_17  = 17'(DEPTH_WORDS);
    localparam logic [15:0]      DEPTH_16  = 16'(DEPTH_WORDS);
    localparam logic [7:0]       HDR_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } ld_state_t;

    // Handshake: r_byte_valid / r_byte_err are one-cycle pulses with no ready; the loader
    // consumes every byte in the cycle it is flagged. imem_we is likewise a one-cycle
    // strobe with no back-pressure, and imem_addr/imem_wdata hold until the next strobe.

    logic            r_rx_meta;
    logic            r_rx_sync;
    logic            r_rx_prev;
    rx_state_t       r_rx_state;
    rx_state_t       w_rx_next;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_rx_shift;
    logic            r_byte_valid;
    logic            r_byte_err;
    logic            w_rx_fall;
    logic            w_tick_half;
    logic            w_tick_bit;
    logic            w_cnt_clear;

    ld_state_t       r_ld_state;
    ld_state_t       w_ld_next;
    logic [15:0]     r_len;
    logic [1:0]      r_byte_idx;
    logic [23:0]     r_word;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_hold;
    logic            r_done;
    logic            r_err;
    logic [15:0]     r_wc;
    logic            w_hdr_seen;
    logic            w_word_done;
    logic            w_last_word;
    logic [16:0]     w_len_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall   = r_rx_prev & ~r_rx_sync;
    assign w_tick_half = (r_rx_cnt == HALF_LAST);
    assign w_tick_bit  = (r_rx_cnt == BIT_LAST);
    assign w_cnt_clear = (r_rx_state == RX_IDLE)
                       || ((r_rx_state == RX_START) && w_tick_half)
                       || (((r_rx_state == RX_DATA) || (r_rx_state == RX_STOP)) && w_tick_bit);

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (w_tick_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick_bit && (r_bit_idx == 3'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_tick_bit) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_cnt     <= '0;
            r_bit_idx    <= 3'd0;
            r_rx_shift   <= 8'd0;
            r_byte_valid <= 1'b0;
            r_byte_err   <= 1'b0;
        end else begin
            r_rx_cnt     <= w_cnt_clear ? '0 : r_rx_cnt + CNT_W'(1);
            r_byte_valid <= (r_rx_state == RX_STOP) && w_tick_bit && r_rx_sync;
            r_byte_err   <= (r_rx_state == RX_STOP) && w_tick_bit && !r_rx_sync;
            if (r_rx_state == RX_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_rx_state == RX_DATA) && w_tick_bit) begin
                r_bit_idx  <= r_bit_idx + 3'd1;
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            end
        end
    end

    assign w_hdr_seen  = r_byte_valid && (r_rx_shift == HDR_BYTE)
                       && ((r_ld_state == S_IDLE) || (r_ld_state == S_DONE) || (r_ld_state == S_ERR));
    assign w_word_done = (r_ld_state == S_DATA) && r_byte_valid && (r_byte_idx == 2'd3);
    assign w_last_word = (({1'b0, r_wc} + 17'd1) == {1'b0, r_len});
    assign w_len_in    = {1'b0, r_rx_shift, r_len[7:0]};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    // Running XOR of LEN_L, LEN_H and every data byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum <= 8'd0;
        end else if (w_hdr_seen) begin
            r_csum <= 8'd0;
        end else if (r_byte_valid && ((r_ld_state == S_LEN0) || (r_ld_state == S_LEN1)
                                      || (r_ld_state == S_DATA))) begin
            r_csum <= r_csum ^ r_rx_shift;
        end
    end
`endif

    always_comb begin
        w_ld_next = r_ld_state;
        case (r_ld_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_hdr_seen) w_ld_next = S_LEN0;
            end
            S_LEN0: begin
                if (r_byte_err)        w_ld_next = S_ERR;
                else if (r_byte_valid) w_ld_next = S_LEN1;
            end
            S_LEN1: begin
                if (r_byte_err) begin
                    w_ld_next = S_ERR;
                end else if (r_byte_valid) begin
                    if (w_len_in == 17'd0)          w_ld_next = S_CSUM;
                    else if (w_len_in > DEPTH_17)   w_ld_next = S_ERR;
                    else                            w_ld_next = S_DATA;
                end
            end
            S_DATA: begin
                if (r_byte_err)                       w_ld_next = S_ERR;
                else if (w_word_done && w_last_word)  w_ld_next = S_CSUM;
            end
            S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (r_byte_err)        w_ld_next = S_ERR;
                else if (r_byte_valid) w_ld_next = (r_rx_shift == r_csum) ? S_DONE : S_ERR;
`else
                w_ld_next = S_DONE;
`endif
            end
            default: w_ld_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_ld_state <= S_IDLE;
        else        r_ld_state <= w_ld_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len      <= 16'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wc       <= 16'd0;
        end else begin
            r_we <= w_word_done;
            if (w_hdr_seen) begin
                r_wc       <= 16'd0;
                r_byte_idx <= 2'd0;
                r_hold     <= 1'b1;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
            end else begin
                // Status follows the terminal states one cycle after they are entered.
                if (r_ld_state == S_DONE) begin
                    r_hold <= 1'b0;
                    r_done <= 1'b1;
                end
                if (r_ld_state == S_ERR) begin
                    r_hold <= 1'b1;
                    r_err  <= 1'b1;
                end
                if ((r_ld_state == S_LEN0) && r_byte_valid) begin
                    r_len[7:0] <= r_rx_shift;
                end
                if ((r_ld_state == S_LEN1) && r_byte_valid) begin
                    r_len[15:8] <= r_rx_shift;
                    r_byte_idx  <= 2'd0;
                end
                if ((r_ld_state == S_DATA) && r_byte_valid) begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        r_addr  <= {14'd0, r_wc, 2'b00};
                        r_wdata <= {r_rx_shift, r_word};
                        if (r_wc != DEPTH_16) r_wc <= r_wc + 16'd1;
                    end else begin
                        r_word <= {r_rx_shift, r_word[23:8]};
                    end
                end
            end
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign cpu_hold     = r_hold;
    assign done         = r_done;
    assign error        = r_err;
    assign word_count   = r_wc;
    assign dbg_state    = r_ld_state;
    assign dbg_rx_state = r_rx_state;

endmodule
